// File: rtl/bus_xfer_seq_if.sv
// Command and bus-strobe bundle for the register transfer sequencer.
// The master issues src->dst transfer commands; the slave (sequencer)
// drives the per-register output/write enables and status.
interface bus_xfer_seq_if #(
  parameter int NREG = 4,
  parameter int SELW = 2
);
  logic            cmd_valid;
  logic [SELW-1:0] cmd_src;
  logic [SELW-1:0] cmd_dst;
  logic            cmd_ready;
  logic [NREG-1:0] oe;
  logic [NREG-1:0] we;
  logic            busy;
  logic            done;
  logic            err;
  logic [7:0]      xfer_count;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, oe, we, busy, done, err, xfer_count
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, oe, we, busy, done, err, xfer_count
  );
endinterface

// File: rtl/bus_xfer_seq.sv
// Register-to-register bus transfer sequencer.
// One accepted command drives register src onto the shared bus for a
// settle cycle, then strobes the write enable of register dst, then
// reports completion. Illegal commands (src==dst or index out of range)
// produce a single error pulse instead. All strobes and status are
// registered; only cmd_ready is combinational.
module bus_xfer_seq #(
  parameter int NREG = 4,
  parameter int SELW = 2
) (
  input logic          clk,
  input logic          rst,
  bus_xfer_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // Register count at select width plus one, so the range check also
  // works when NREG equals 2**SELW.
  localparam logic [SELW:0] NREG_W = (SELW+1)'(NREG);

  logic [2:0]      state_reg, state_next;
  logic [SELW-1:0] src_reg, src_next;
  logic [SELW-1:0] dst_reg, dst_next;
  logic [NREG-1:0] src_dec, dst_dec;
  logic [NREG-1:0] oe_reg, we_reg;
  logic            busy_reg, done_reg, err_reg;
  logic [7:0]      count_reg;
  logic            cmd_ready;
  logic            accept;
  logic            cmd_legal;

  // Ready only in IDLE and never while reset is asserted, so a command
  // presented together with reset is not consumed.
  assign cmd_ready = (state_reg == S_IDLE) && !rst;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign cmd_legal = (bus.cmd_src != bus.cmd_dst) &&
                     ({1'b0, bus.cmd_src} < NREG_W) &&
                     ({1'b0, bus.cmd_dst} < NREG_W);

  // Next-state and operand capture; operands are frozen at the accept
  // edge so later command changes cannot disturb a transfer in flight.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          src_next   = bus.cmd_src;
          dst_next   = bus.cmd_dst;
          state_next = cmd_legal ? S_DRIVE : S_ERR;
        end
      end
      S_DRIVE: state_next = S_LATCH;
      S_LATCH: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One-hot decode of the operands that will be held next cycle, so the
  // strobes can be registered in step with the state.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign src_dec[gi] = (src_next == SELW'(gi));
      assign dst_dec[gi] = (dst_next == SELW'(gi));
    end
  endgenerate

  // State, operand, strobe and counter registers; reset aborts any
  // transfer without a done pulse or count update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      oe_reg    <= '0;
      we_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      oe_reg    <= ((state_next == S_DRIVE) || (state_next == S_LATCH)) ? src_dec : '0;
      we_reg    <= (state_next == S_LATCH) ? dst_dec : '0;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_next == S_DONE);
      err_reg   <= (state_next == S_ERR);
      // Count on the edge leaving DONE; wraps 255 -> 0 silently.
      if (state_reg == S_DONE) begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.oe         = oe_reg;
  assign bus.we         = we_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.xfer_count = count_reg;

endmodule

// File: doc/bus_xfer_seq.md
BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 Parameter NREG, default 4: number of bus registers controlled; legal range 2..4.
REQ-002 Parameter SELW, default 2: width of register select fields.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  transfer command present.
REQ-006 cmd_src  input  SELW  index of register to drive the bus.
REQ-007 cmd_dst  input  SELW  index of register to load from the bus.
REQ-008 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-009 oe  output  NREG  per-register output enable, one-hot or zero.
REQ-010 we  output  NREG  per-register write enable, one-hot or zero.
REQ-011 busy  output  1  transfer or error sequence in progress.
REQ-012 done  output  1  one-cycle pulse, transfer completed.
REQ-013 err  output  1  one-cycle pulse, command rejected.
REQ-014 xfer_count  output  8  completed-transfer counter.

Function
REQ-015 States SHALL be IDLE, DRIVE, LATCH, DONE, ERR; all outputs registered except cmd_ready.
REQ-016 cmd_ready SHALL equal (state==IDLE) and not rst.
REQ-017 Command accepted at a rising edge where cmd_valid=1 and cmd_ready=1; operands captured into internal src/dst registers at that edge.
REQ-018 Accept with cmd_src!=cmd_dst and both indices < NREG -> DRIVE; otherwise -> ERR.
REQ-019 DRIVE (1 cycle): oe[src]=1, we=0, busy=1 (bus settle); next state LATCH.
REQ-020 LATCH (1 cycle): oe[src]=1, we[dst]=1, busy=1; next state DONE.
REQ-021 DONE (1 cycle): oe=0, we=0, done=1, busy=1; xfer_count increments by 1 at the edge leaving DONE; next state IDLE.
REQ-022 ERR (1 cycle): oe=0, we=0, err=1, busy=1, xfer_count unchanged; next state IDLE.
REQ-023 Latency: accept edge to done high = 3 cycles; back-to-back throughput one transfer per 4 cycles.
REQ-024 cmd_src/cmd_dst changes after acceptance SHALL not affect the transfer in progress.
REQ-025 cmd_valid while busy SHALL be ignored (not queued); master holds it until cmd_ready.
REQ-026 At most one bit of oe and one bit of we SHALL be high in any cycle; we SHALL never be high without oe high.
REQ-027 xfer_count SHALL wrap 255 -> 0 without flag.
REQ-028 done and err SHALL never be high in the same cycle.
REQ-029 IDLE: oe=0, we=0, busy=0, done=0, err=0.

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, oe=0, we=0, busy=0, done=0, err=0, xfer_count=0, src/dst=0.
REQ-031 rst mid-transfer (any state) SHALL abort it: strobes low from the next cycle, no done, no count increment.
REQ-032 rst=1 with cmd_valid=1 SHALL not accept the command (cmd_ready=0 during rst).
REQ-033 First command may be accepted at the first edge with rst=0.

Verification
REQ-034 After reset, cmd_valid=1 src=1 dst=2 for one accepted edge -> cycle+1 oe=0010 we=0000; +2 oe=0010 we=0100; +3 done=1 strobes 0; +4 cmd_ready=1, xfer_count=1.
REQ-035 src=3 dst=3 accepted -> next cycle err=1, oe=we=0, done=0; following cycle IDLE, xfer_count unchanged.
REQ-036 cmd_valid held high with src=0 dst=1 for 12 cycles -> exactly 3 done pulses 4 cycles apart, xfer_count=3, no command accepted while busy=1.
REQ-037 rst asserted during LATCH -> next cycle oe=we=0, busy=0, xfer_count=0, no done pulse.
REQ-038 Preload count via 255 transfers, then one more -> xfer_count=0 after its DONE state.
REQ-039 Every cycle of every scenario: onehot0(oe), onehot0(we), we!=0 implies oe!=0, !(done&&err).
